// File: rtl/st7789_stream_arbiter.sv
// Packet-granular round-robin arbiter: two FWFT FIFO read ports share one AXI-Stream master.
// Grant one cycle after data is seen, first beat one cycle later; pops stall while a beat waits on TREADY.
module st7789_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1
) (
  input  logic                    M_AXIS_CLK,
  input  logic                    M_AXIS_RESETN,
  input  logic [DATA_WIDTH-1:0]   CH0_DOUT_DATA,
  input  logic [DATA_WIDTH/8-1:0] CH0_DOUT_KEEP,
  input  logic [USER_WIDTH-1:0]   CH0_DOUT_USER,
  input  logic                    CH0_DOUT_LAST,
  input  logic                    CH0_EMPTY,
  output logic                    CH0_RDEN,
  input  logic [DATA_WIDTH-1:0]   CH1_DOUT_DATA,
  input  logic [DATA_WIDTH/8-1:0] CH1_DOUT_KEEP,
  input  logic [USER_WIDTH-1:0]   CH1_DOUT_USER,
  input  logic                    CH1_DOUT_LAST,
  input  logic                    CH1_EMPTY,
  output logic                    CH1_RDEN,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic [USER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    BUSY,
  output logic                    GRANT_CH
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]              r_state;
  logic                    r_grant;
  logic                    r_last_grant;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [DATA_WIDTH/8-1:0] r_tkeep;
  logic [USER_WIDTH-1:0]   r_tuser;
  logic                    r_tlast;
  logic                    r_tvalid;

  logic                    w_out_free;
  logic                    w_head_empty;
  logic [DATA_WIDTH-1:0]   w_head_data;
  logic [DATA_WIDTH/8-1:0] w_head_keep;
  logic [USER_WIDTH-1:0]   w_head_user;
  logic                    w_head_last;
  logic                    w_pop;
  logic                    w_any;
  logic                    w_pick;

  // Head word of whichever FIFO currently holds the grant.
  assign w_head_empty = r_grant ? CH1_EMPTY     : CH0_EMPTY;
  assign w_head_data  = r_grant ? CH1_DOUT_DATA : CH0_DOUT_DATA;
  assign w_head_keep  = r_grant ? CH1_DOUT_KEEP : CH0_DOUT_KEEP;
  assign w_head_user  = r_grant ? CH1_DOUT_USER : CH0_DOUT_USER;
  assign w_head_last  = r_grant ? CH1_DOUT_LAST : CH0_DOUT_LAST;

  assign w_out_free = !r_tvalid || M_AXIS_TREADY;
  assign w_pop      = M_AXIS_RESETN && (r_state == ST_LOCKED) && !w_head_empty && w_out_free;
  assign w_any      = !(CH0_EMPTY && CH1_EMPTY);

  always_comb begin
    w_pick = 1'b0;
    case ({CH1_EMPTY, CH0_EMPTY})
      2'b10:   w_pick = 1'b0;
      2'b01:   w_pick = 1'b1;
      2'b00:   w_pick = ~r_last_grant;
      default: w_pick = 1'b0;
    endcase
  end

  assign CH0_RDEN = w_pop && !r_grant;
  assign CH1_RDEN = w_pop &&  r_grant;

  always_ff @(posedge M_AXIS_CLK) begin
    if (!M_AXIS_RESETN) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_LOCKED;
            r_grant <= w_pick;
          end
        end
        ST_LOCKED: begin
          // Lock is held across empty gaps; only a popped LAST releases it.
          if (w_pop && w_head_last) begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXIS_CLK) begin
    if (!M_AXIS_RESETN) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_pop) begin
      r_tdata  <= w_head_data;
      r_tkeep  <= w_head_keep;
      r_tuser  <= w_head_user;
      r_tlast  <= w_head_last;
      r_tvalid <= 1'b1;
    end else if (r_tvalid && M_AXIS_TREADY) begin
      r_tvalid <= 1'b0;
    end
  end

  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TKEEP  = r_tkeep;
  assign M_AXIS_TUSER  = r_tuser;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TVALID = r_tvalid;
  assign BUSY          = (r_state == ST_LOCKED);
  assign GRANT_CH      = r_grant;

endmodule

// File: tb/tb_st7789_stream_arbiter.sv
// Scoreboard bench for st7789_stream_arbiter: FIFO models feed the DUT, a negedge monitor checks beats and per-cycle rules.
`timescale 1ns/1ps
module tb_st7789_stream_arbiter;
  localparam int DW = 16;
  localparam int UW = 1;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk;
  logic          resetn;
  logic [DW-1:0] ch0_data, ch1_data;
  logic [KW-1:0] ch0_keep, ch1_keep;
  logic [UW-1:0] ch0_user, ch1_user;
  logic          ch0_last, ch1_last;
  logic          ch0_empty, ch1_empty;
  logic          ch0_rden, ch1_rden;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tlast, tvalid, tready;
  logic          busy, grant_ch;

  st7789_stream_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .M_AXIS_CLK(clk), .M_AXIS_RESETN(resetn),
    .CH0_DOUT_DATA(ch0_data), .CH0_DOUT_KEEP(ch0_keep), .CH0_DOUT_USER(ch0_user),
    .CH0_DOUT_LAST(ch0_last), .CH0_EMPTY(ch0_empty), .CH0_RDEN(ch0_rden),
    .CH1_DOUT_DATA(ch1_data), .CH1_DOUT_KEEP(ch1_keep), .CH1_DOUT_USER(ch1_user),
    .CH1_DOUT_LAST(ch1_last), .CH1_EMPTY(ch1_empty), .CH1_RDEN(ch1_rden),
    .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TUSER(tuser),
    .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .BUSY(busy), .GRANT_CH(grant_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // FIFO contents (fq*) and expected output words per channel (ex*)
  beat_t fq0[$], fq1[$], ex0[$], ex1[$];
  bit    inflight[$];
  bit    pop0, pop1;
  int    pkt_log[$], grant_log[$], pkt_cyc[$], last_cyc[$], acc_cyc[$];
  int    acc_cnt = 0;
  bit    starve_watch = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input beat_t b);
    if (ch == 0) begin fq0.push_back(b); ex0.push_back(b); end
    else         begin fq1.push_back(b); ex1.push_back(b); end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d; b.keep = '1; b.user = '0; b.last = l;
    return b;
  endfunction

  task automatic clear_logs();
    pkt_log.delete(); grant_log.delete(); pkt_cyc.delete(); last_cyc.delete(); acc_cyc.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO model: applies pops seen at the previous negedge, then presents head words.
  initial begin
    ch0_empty = 1'b1; ch1_empty = 1'b1;
    {ch0_data, ch0_keep, ch0_user, ch0_last} = '0;
    {ch1_data, ch1_keep, ch1_user, ch1_last} = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pop0 && fq0.size() > 0) fq0.delete(0);
      if (pop1 && fq1.size() > 0) fq1.delete(0);
      pop0 = 1'b0; pop1 = 1'b0;
      ch0_empty = (fq0.size() == 0);
      ch1_empty = (fq1.size() == 0);
      {ch0_data, ch0_keep, ch0_user, ch0_last} = ch0_empty ? '0 : fq0[0];
      {ch1_data, ch1_keep, ch1_user, ch1_last} = ch1_empty ? '0 : fq1[0];
    end
  end

  // Monitor
  bit    prev_rst = 0, prev_vld = 0, prev_rdy = 0, prev_busy = 0, in_pkt = 0, cur_ch = 0;
  beat_t prev_beat;
  initial begin
    forever begin
      beat_t cur, expb;
      bit    ch, e0, e1;
      @(negedge clk);
      cur = {tdata, tkeep, tuser, tlast};
      if (!resetn) begin
        check_eq("rden_in_reset", {ch0_rden, ch1_rden}, 2'b00);
        while (inflight.size() > 0) begin
          ch = inflight.pop_front();
          if (ch == 1'b0 && ex0.size() > 0) ex0.delete(0);
          if (ch == 1'b1 && ex1.size() > 0) ex1.delete(0);
        end
        in_pkt = 1'b0;
      end else begin
        e0 = busy && !grant_ch && !ch0_empty && (!tvalid || tready);
        e1 = busy &&  grant_ch && !ch1_empty && (!tvalid || tready);
        check_eq("rden0_rule", ch0_rden, e0);
        check_eq("rden1_rule", ch1_rden, e1);
        check_eq("rden_while_empty", (ch0_rden && ch0_empty) || (ch1_rden && ch1_empty), 1'b0);
        if (prev_rst && prev_vld && !prev_rdy)
          check_eq("hold_stable", {tvalid, cur}, {1'b1, prev_beat});
        if (tvalid && tready) begin
          if (inflight.size() == 0) begin
            check_eq("spurious_beat", cur, '0);
          end else begin
            ch = inflight.pop_front();
            if (ch == 1'b0 && ex0.size() > 0) expb = ex0.pop_front();
            else if (ch == 1'b1 && ex1.size() > 0) expb = ex1.pop_front();
            else expb = '0;
            check_eq(ch ? "beat_ch1" : "beat_ch0", cur, expb);
            if (in_pkt) check_eq("no_interleave", ch, cur_ch);
            if (!in_pkt) begin pkt_log.push_back(int'(ch)); pkt_cyc.push_back(cyc); end
            if (cur.last) last_cyc.push_back(cyc);
            in_pkt = !cur.last;
            cur_ch = ch;
            acc_cyc.push_back(cyc);
            acc_cnt++;
            if (starve_watch && ch == 1'b1 && cur.data == 16'h00A1) starve_watch = 1'b0;
          end
        end
        if (starve_watch) check_eq("ch0_starved_during_lock", ch0_rden, 1'b0);
        if (ch0_rden) begin inflight.push_back(1'b0); pop0 = 1'b1; end
        if (ch1_rden) begin inflight.push_back(1'b1); pop1 = 1'b1; end
        if (busy && !prev_busy) grant_log.push_back(int'(grant_ch));
      end
      prev_rst  = resetn;
      prev_vld  = tvalid;
      prev_rdy  = tready;
      prev_beat = cur;
      prev_busy = busy && resetn;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    @(negedge clk); #1;
    while ((ex0.size() > 0 || ex1.size() > 0 || busy || tvalid) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("drain_within_budget", n < budget, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, base, n, rem[2];
    beat_t b;
    resetn = 1'b0;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", tvalid, 1'b0);
    check_eq("rst_tdata", {tdata, tkeep, tuser, tlast}, '0);
    check_eq("rst_busy_grant", {busy, grant_ch}, 2'b00);
    check_eq("rst_rden", {ch0_rden, ch1_rden}, 2'b00);

    // Single 4-word packet on CH0
    @(posedge clk); #1 resetn = 1'b1; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear_logs(); t0 = cyc;
    for (int i = 1; i <= 4; i++) push(0, mk(DW'(i), i == 4));
    wait_drain(100);
    check_eq("single_beats", acc_cyc.size(), 4);
    for (int i = 0; i < 4 && i < acc_cyc.size(); i++)
      check_eq("single_beat_cycle", acc_cyc[i], t0 + 2 + i);
    check_eq("single_busy_after", busy, 1'b0);

    // Contention from reset: CH0, CH1, CH0 with one bubble between packets
    @(posedge clk); #1 resetn = 1'b0;
    push(0, mk(16'h0011, 0)); push(0, mk(16'h0012, 1));
    push(0, mk(16'h0013, 0)); push(0, mk(16'h0014, 1));
    push(1, mk(16'h0021, 0)); push(1, mk(16'h0022, 1));
    repeat (2) @(posedge clk);
    #1 clear_logs(); resetn = 1'b1;
    wait_drain(100);
    check_eq("contention_grants", grant_log.size(), 3);
    check_eq("contention_pkts", pkt_log.size(), 3);
    if (grant_log.size() == 3) begin
      check_eq("grant_0", grant_log[0], 0);
      check_eq("grant_1", grant_log[1], 1);
      check_eq("grant_2", grant_log[2], 0);
    end
    if (pkt_log.size() == 3 && last_cyc.size() == 3) begin
      check_eq("pkt_order", {pkt_log[0][0], pkt_log[1][0], pkt_log[2][0]}, 3'b010);
      check_eq("bubble_1", pkt_cyc[1] - last_cyc[0], 2);
      check_eq("bubble_2", pkt_cyc[2] - last_cyc[1], 2);
    end

    // Backpressure: TREADY 1,0,0,1 during a 3-word packet
    @(posedge clk); #1 clear_logs(); base = acc_cnt;
    push(0, mk(16'h0031, 0)); push(0, mk(16'h0032, 0)); push(0, mk(16'h0033, 1));
    n = 0;
    do begin @(negedge clk); n++; end while (!tvalid && n < 20);
    check_eq("bp_first_valid", tdata, 16'h0031);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 tready = (k == 2);
      @(negedge clk);
      if (k < 2) begin
        check_eq("bp_no_rden_stalled", ch0_rden, 1'b0);
        check_eq("bp_hold_word", {tvalid, tdata}, {1'b1, 16'h0032});
      end
    end
    wait_drain(100);
    check_eq("bp_beat_count", acc_cnt - base, 3);

    // Starvation: CH1 packet with a gap, CH0 arrives in the gap
    @(posedge clk); #1 clear_logs();
    push(1, mk(16'h00A0, 0)); starve_watch = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) push(0, mk(16'h0055, 1));
      @(negedge clk);
      if (i >= 3) begin
        check_eq("gap_tvalid_low", tvalid, 1'b0);
        check_eq("gap_lock_ch1", {busy, grant_ch}, 2'b11);
      end
    end
    @(posedge clk); #1 push(1, mk(16'h00A1, 1));
    wait_drain(100);
    check_eq("starve_order", pkt_log.size() == 2 && pkt_log[0] == 1 && pkt_log[1] == 0, 1'b1);
    check_eq("starve_watch_cleared", starve_watch, 1'b0);

    // Reset mid-packet after 2 of 4 beats
    @(posedge clk); #1 base = acc_cnt;
    push(0, mk(16'h0041, 0)); push(0, mk(16'h0042, 0));
    n = 0;
    while (acc_cnt - base < 2 && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("rstmid_two_beats", acc_cnt - base, 2);
    @(posedge clk); #1 resetn = 1'b0;
    push(0, mk(16'h0043, 0)); push(0, mk(16'h0044, 1));
    @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_after", {tvalid, busy, ch0_rden, ch1_rden}, 4'b0000);
    @(posedge clk); #1 clear_logs(); base = acc_cnt; resetn = 1'b1;
    wait_drain(100);
    check_eq("rstmid_resume_beats", acc_cnt - base, 2);
    check_eq("rstmid_resume_pkt", pkt_log.size() == 1 && pkt_log[0] == 0 && last_cyc.size() == 1, 1'b1);

    // Randomized traffic with random backpressure
    rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      tready = ($urandom_range(3) != 0);
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(2) == 0) begin
          if (rem[ch] == 0) rem[ch] = $urandom_range(6, 1);
          b.data = DW'($urandom); b.keep = KW'($urandom); b.user = UW'($urandom);
          b.last = (rem[ch] == 1);
          push(ch, b);
          rem[ch]--;
        end
      end
    end
    @(posedge clk); #1 tready = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      while (rem[ch] > 0) begin
        b.data = DW'($urandom); b.keep = KW'($urandom); b.user = UW'($urandom);
        b.last = (rem[ch] == 1);
        push(ch, b);
        rem[ch]--;
      end
    end
    wait_drain(2000);
    check_eq("random_all_delivered", ex0.size() + ex1.size() + inflight.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/st7789_stream_arbiter.md
ST7789_STREAM_ARBITER -- requirements
Module: st7789_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the data field in bits (multiple of 8).
REQ-002 Parameter USER_WIDTH, default 1, width of the user field in bits.
REQ-003 Port M_AXIS_CLK  input  1  single clock for all logic.
REQ-004 Port M_AXIS_RESETN  input  1  reset, synchronous to M_AXIS_CLK, active-low.
REQ-005 Ports CHn_DOUT_DATA/KEEP/USER/LAST  input  DATA_WIDTH/DATA_WIDTH/8/USER_WIDTH/1  FWFT head word of FIFO n, n in {0,1}.
REQ-006 Port CHn_EMPTY  input  1  FIFO n empty; head word valid when low.
REQ-007 Port CHn_RDEN  output  1  pop head word of FIFO n.
REQ-008 Ports M_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID  output  DATA_WIDTH/DATA_WIDTH/8/USER_WIDTH/1/1  AXI-Stream master.
REQ-009 Port M_AXIS_TREADY  input  1  downstream ready.
REQ-010 Port BUSY  output  1  high while a channel is granted.
REQ-011 Port GRANT_CH  output  1  granted channel index; meaningful only when BUSY.

Function
REQ-012 The block SHALL share one AXI-Stream master between two FWFT FIFO read ports at packet granularity; a packet ends on a word with LAST=1.
REQ-013 FSM states SHALL be IDLE and LOCKED; BUSY=1 exactly in LOCKED.
REQ-014 IDLE: if exactly one CHn_EMPTY is low, that channel SHALL be granted and the FSM SHALL enter LOCKED on the next edge.
REQ-015 IDLE: if both are non-empty, the channel other than last_grant SHALL be granted (round-robin); last_grant resets to 1, so channel 0 wins the first contest.
REQ-016 IDLE: no RDEN SHALL be asserted; if both are empty, remain IDLE.
REQ-017 LOCKED: CHg_RDEN SHALL be high iff CHg_EMPTY=0 and (M_AXIS_TVALID=0 or M_AXIS_TREADY=1), g = granted channel; the other RDEN SHALL be 0.
REQ-018 An RDEN pop SHALL load that head word into the output register on the same edge and set M_AXIS_TVALID=1; otherwise, an accepted beat (TVALID&TREADY) SHALL clear TVALID.
REQ-019 Output register SHALL hold TDATA/TKEEP/TUSER/TLAST stable while TVALID=1 and TREADY=0.
REQ-020 A pop with LAST=1 SHALL set last_grant=g and return the FSM to IDLE on the same edge; the next grant decision occurs in the following cycle (one bubble cycle between packets).
REQ-021 Latency: FIFO word present with channel locked and output register free -> M_AXIS_TVALID high one cycle later; from IDLE with data arriving at cycle t -> LOCKED at t+1, TVALID at t+2.
REQ-022 Throughput within a packet SHALL be one beat per cycle while TREADY=1 and the FIFO is non-empty.
REQ-023 Granted FIFO going empty mid-packet SHALL keep the lock (no preemption) until LAST is popped; the other channel is not served meanwhile.
REQ-024 A CHn_RDEN SHALL never be asserted while CHn_EMPTY=1.
REQ-025 Arrival on the other channel during LOCKED SHALL not affect the current packet.

Reset
REQ-026 With M_AXIS_RESETN=0 at a clock edge: state=IDLE, last_grant=1, M_AXIS_TVALID=0, TDATA/TKEEP/TUSER/TLAST=0, CH0_RDEN=CH1_RDEN=0, BUSY=0, GRANT_CH=0.
REQ-027 Reset mid-packet SHALL drop the output register contents and lock; FIFOs are not reset by this block and any remaining words of the interrupted packet are treated as a new packet after reset.
REQ-028 RDEN outputs SHALL be 0 during the reset cycle regardless of EMPTY.

Verification
REQ-029 Single packet: CH0 holds 4 words 0x0001..0x0004 (LAST on 4th), CH1 empty, TREADY=1 -> TVALID at t+2, 4 consecutive beats, TLAST on 0x0004, then BUSY=0.
REQ-030 Contention: both FIFOs hold 2-word packets from reset -> order CH0 pkt, bubble, CH1 pkt, bubble, CH0 pkt; GRANT_CH toggles 0,1,0.
REQ-031 Backpressure: TREADY toggled 1,0,0,1 during a 3-word packet -> no RDEN while TVALID=1 and TREADY=0, TDATA stable, all 3 words delivered in order, none duplicated.
REQ-032 Starvation mid-packet: CH1 packet 0xA0,(gap 5 cycles),0xA1 LAST, CH0 data arriving in the gap -> CH0 not served until 0xA1 accepted; TVALID low during gap.
REQ-033 Reset mid-packet: assert M_AXIS_RESETN=0 after 2 of 4 beats -> next cycle TVALID=0, BUSY=0, no RDEN; after release, remaining 2 words emitted as a packet ending in LAST.
REQ-034 Checker on every cycle: no RDEN while EMPTY, at most one RDEN high, AXI-Stream stability rule holds.
